// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM encoding,
// block geometry and word select/merge helpers.
package data_cache_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_BITS = 2;
  localparam int BLOCK_BITS  = 128;
  localparam int WORD_BITS   = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  function automatic logic [WORD_BITS-1:0] block_word(
    input logic [BLOCK_BITS-1:0]  blk,
    input logic [OFFSET_BITS-1:0] off
  );
    logic [WORD_BITS-1:0] w;
    case (off)
      2'd0:    w = blk[31:0];
      2'd1:    w = blk[63:32];
      2'd2:    w = blk[95:64];
      2'd3:    w = blk[127:96];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  // Replace one word of a block, leaving the other three untouched.
  function automatic logic [BLOCK_BITS-1:0] block_merge(
    input logic [BLOCK_BITS-1:0]  blk,
    input logic [OFFSET_BITS-1:0] off,
    input logic [WORD_BITS-1:0]   word
  );
    logic [BLOCK_BITS-1:0] r;
    r = blk;
    case (off)
      2'd0:    r[31:0]   = word;
      2'd1:    r[63:32]  = word;
      2'd2:    r[95:64]  = word;
      2'd3:    r[127:96] = word;
      default: r = blk;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_cache_line_array.sv
// Line storage for the data cache: data/tag arrays plus valid/dirty bits.
// Combinational read of the addressed line; clocked word-write and block-fill.
module data_cache_line_array
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES  = 8,
  parameter int INDEX_BITS = $clog2(NUM_LINES),
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  index,
  output logic [TAG_BITS-1:0]    line_tag,
  output logic                   line_valid,
  output logic                   line_dirty,
  output logic [BLOCK_BITS-1:0]  line_block,
  input  logic                   word_we,
  input  logic [OFFSET_BITS-1:0] word_offset,
  input  logic [WORD_BITS-1:0]   word_data,
  input  logic                   fill_we,
  input  logic [TAG_BITS-1:0]    fill_tag,
  input  logic [BLOCK_BITS-1:0]  fill_block
);

  logic [BLOCK_BITS-1:0] data_mem [NUM_LINES];
  logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0]  valid;
  logic [NUM_LINES-1:0]  dirty;

  assign line_tag   = tag_mem[index];
  assign line_valid = valid[index];
  assign line_dirty = dirty[index];
  assign line_block = data_mem[index];

  // A fill leaves the line clean; a CPU store marks it dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= {NUM_LINES{1'b0}};
      dirty <= {NUM_LINES{1'b0}};
    end else if (fill_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (word_we) begin
      dirty[index] <= 1'b1;
    end
  end

  // Payload arrays are deliberately not reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[index] <= fill_block;
      tag_mem[index]  <= fill_tag;
    end else if (word_we) begin
      data_mem[index] <= block_merge(data_mem[index], word_offset, word_data);
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the CPU MEM stage.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [31:0]           ADDRESS,
  input  logic [31:0]           WRITEDATA,
  output logic [31:0]           READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [27:0]           MEM_ADDRESS,
  output logic [BLOCK_BITS-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_BITS-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic [31:0]           HIT_COUNT,
  output logic [31:0]           MISS_COUNT
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = 28 - INDEX_BITS;

  state_t                 state;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic [OFFSET_BITS-1:0] offset;
  logic [TAG_BITS-1:0]    line_tag;
  logic                   line_valid;
  logic                   line_dirty;
  logic [BLOCK_BITS-1:0]  line_block;
  logic [BLOCK_BITS-1:0]  fill_block;
  logic                   access;
  logic                   hit;
  logic                   word_we;
  logic                   fill_we;
  logic                   unused_addr_bits;

  assign index            = ADDRESS[3+INDEX_BITS:4];
  assign tag              = ADDRESS[31:4+INDEX_BITS];
  assign offset           = ADDRESS[3:2];
  assign unused_addr_bits = ^ADDRESS[1:0];

  assign access   = READ | WRITE;
  assign hit      = line_valid & (line_tag == tag);
  assign BUSYWAIT = (access & ~hit) | (state != IDLE);
  assign READDATA = (READ & hit) ? block_word(line_block, offset) : 32'd0;

  // A simultaneous READ and WRITE is a store.
  assign word_we = (state == IDLE) & WRITE & hit;
  assign fill_we = (state == UPDATE);

  data_cache_line_array #(
    .NUM_LINES (NUM_LINES)
  ) u_lines (
    .clk         (CLK),
    .rst         (RESET),
    .index       (index),
    .line_tag    (line_tag),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .line_block  (line_block),
    .word_we     (word_we),
    .word_offset (offset),
    .word_data   (WRITEDATA),
    .fill_we     (fill_we),
    .fill_tag    (tag),
    .fill_block  (fill_block)
  );

  // Miss handling FSM; memory request outputs are set on state entry and
  // cleared on exit so they track the state exactly.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= 28'd0;
      MEM_WRITEDATA <= {BLOCK_BITS{1'b0}};
      fill_block    <= {BLOCK_BITS{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (access && !hit) begin
            if (line_dirty) begin
              state         <= WRITE_BACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {line_tag, index};
              MEM_WRITEDATA <= line_block;
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {tag, index};
            end
          end
        end
        WRITE_BACK: begin
          if (!MEM_BUSYWAIT) begin
            state       <= FETCH;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {tag, index};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state      <= UPDATE;
            MEM_READ   <= 1'b0;
            fill_block <= MEM_READDATA;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // Saturating counters; the post-refill re-evaluation counts as a hit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if (state == IDLE && access) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_count;
  assign MISS_COUNT = miss_count;
`else
  assign HIT_COUNT  = 32'd0;
  assign MISS_COUNT = 32'd0;
`endif

endmodule
